// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 9-bit instructions from an external ROM,
// executes them on an NREG x DATA_W register file, and paces the ROM with a step pulse.
module control_unit #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        instruction,
    input  logic [DATA_W-1:0] data_var,
    output logic              step,
    output logic              done,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_ALU,
        S_STEP,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;

    state_t              state_q, state_d;
    logic [8:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   dr_q, dr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                step_q, done_q;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic                we;
    logic [DATA_W-1:0]   wdata;

    logic [2:0] opc, rx, ry;
    assign opc = ir_q[8:6];
    assign rx  = ir_q[5:3];
    assign ry  = ir_q[2:0];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        dr_d    = dr_q;
        a_d     = a_q;
        b_d     = b_q;
        we      = 1'b0;
        wdata   = '0;
        case (state_q)
            S_FETCH: begin
                ir_d    = instruction;
                dr_d    = data_var;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opc)
                    OP_LOAD: begin
                        we      = 1'b1;
                        wdata   = dr_q;
                        state_d = S_STEP;
                    end
                    OP_MOVE: begin
                        we      = 1'b1;
                        wdata   = regs_q[ry];
                        state_d = S_STEP;
                    end
                    OP_ADD, OP_XOR: begin
                        // Operands are captured before writeback so rx==ry behaves.
                        a_d     = regs_q[rx];
                        b_d     = regs_q[ry];
                        state_d = S_ALU;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_STEP;
                endcase
            end
            S_ALU: begin
                we      = 1'b1;
                wdata   = (opc == OP_ADD) ? (a_q + b_q) : (a_q ^ b_q);
                state_d = S_STEP;
            end
            S_STEP:  state_d = S_WAIT;
            S_WAIT:  state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are registered copies of the state being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            dr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= (state_d == S_STEP);
            done_q  <= (state_d == S_HALT);
            if (we) regs_q[rx] <= wdata;
        end
    end

    assign step     = step_q;
    assign done     = done_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a ROM model driven by step, table-driven programs with a
// scoreboard of expected register writes, plus timing, reset and halt-hold sequences.
module tb_control_unit;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [8:0]    instruction = '0;
    logic [DW-1:0] data_var = '0;
    logic          step, done;
    logic [2:0]    dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    control_unit #(.DATA_W(DW), .NREG(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .data_var   (data_var),
        .step       (step),
        .done       (done),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]    ins;
        logic [DW-1:0] dv;
        logic [2:0]    chk;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]    r;
        logic [DW-1:0] v;
    } exp_t;

    vec_t          tbl[$];
    exp_t          sbq[$];
    logic [8:0]    rom_i [32];
    logic [DW-1:0] rom_d [32];
    int            pc;
    int            nvec = 0;
    int            nbad = 0;
    int            nsteps;
    int            step_cyc[$];

    function automatic vec_t mk(input logic [8:0] ins, input logic [DW-1:0] dv,
                                input logic [2:0] c, input logic [DW-1:0] e);
        vec_t v;
        v.ins = ins; v.dv = dv; v.chk = c; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reg(input string nm, input logic [2:0] r, input logic [DW-1:0] v);
        dbg_sel = r;
        #1;
        chk(nm, {16'h0, dbg_data}, {16'h0, v});
    endtask

    task automatic drive_rom();
        instruction = rom_i[pc];
        data_var    = rom_d[pc];
    endtask

    // Copy one halt-terminated program into the ROM and queue its expected writes.
    task automatic load_prog(input int first, output int nxt);
        int k = first;
        int a = 0;
        exp_t e;
        sbq.delete();
        for (int i = 0; i < 32; i++) begin
            rom_i[i] = 9'b100_000_000;
            rom_d[i] = '0;
        end
        while (1) begin
            rom_i[a] = tbl[k].ins;
            rom_d[a] = tbl[k].dv;
            if (tbl[k].ins[8:6] == 3'b100) break;
            e.r = tbl[k].chk; e.v = tbl[k].exp;
            sbq.push_back(e);
            k++; a++;
        end
        nxt = k + 1;
        pc  = 0;
        drive_rom();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Cycle 1 is the FETCH cycle that follows reset release.
    task automatic run(input int budget);
        int   cyc = 0;
        logic prev = 1'b0;
        exp_t e;
        step_cyc.delete();
        nsteps = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (step) begin
                nsteps++;
                step_cyc.push_back(cyc);
                chk("step_back_to_back", {31'h0, prev}, 32'h0);
                chk("step_while_done", {31'h0, done}, 32'h0);
                if (sbq.size() == 0) begin
                    nvec++; nbad++;
                    $display("FAIL sb_underflow: got step at cycle %0d expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check_reg($sformatf("R%0d_after_step%0d", e.r, nsteps), e.r, e.v);
                end
                pc++;
                drive_rom();
            end
            prev = step;
            if (done) break;
            if (cyc >= budget) begin
                nvec++; nbad++;
                $display("FAIL run_timeout: got no done after %0d cycles expected done", cyc);
                break;
            end
        end
        chk("sb_drained", sbq.size(), 32'h0);
    endtask

    initial begin
        int nxt;
        int pT, pB, pR, pS;
        // Program A: the reference program
        tbl.push_back(mk(9'b000_000_000, 16'd9,    3'd0, 16'd9));
        tbl.push_back(mk(9'b001_001_000, 16'd0,    3'd1, 16'd9));
        tbl.push_back(mk(9'b001_010_000, 16'd0,    3'd2, 16'd9));
        tbl.push_back(mk(9'b010_001_000, 16'd0,    3'd1, 16'd18));
        tbl.push_back(mk(9'b011_010_001, 16'd0,    3'd2, 16'd27));
        tbl.push_back(mk(9'b100_000_000, 16'd0,    3'd0, 16'd0));
        // Program T: timing (load, move, add)
        pT = tbl.size();
        tbl.push_back(mk(9'b000_000_000, 16'd9,    3'd0, 16'd9));
        tbl.push_back(mk(9'b001_001_000, 16'd0,    3'd1, 16'd9));
        tbl.push_back(mk(9'b010_001_000, 16'd0,    3'd1, 16'd18));
        tbl.push_back(mk(9'b100_000_000, 16'd0,    3'd0, 16'd0));
        // Program B: wrap-around, self-operands, NOP opcodes
        pB = tbl.size();
        tbl.push_back(mk(9'b000_011_000, 16'hFFFF, 3'd3, 16'hFFFF));
        tbl.push_back(mk(9'b010_011_011, 16'h0,    3'd3, 16'hFFFE));
        tbl.push_back(mk(9'b011_011_011, 16'h0,    3'd3, 16'h0000));
        tbl.push_back(mk(9'b000_100_000, 16'h1234, 3'd4, 16'h1234));
        tbl.push_back(mk(9'b110_100_100, 16'hBEEF, 3'd4, 16'h1234));
        tbl.push_back(mk(9'b000_101_000, 16'h00A5, 3'd5, 16'h00A5));
        tbl.push_back(mk(9'b011_101_100, 16'h0,    3'd5, 16'h1291));
        tbl.push_back(mk(9'b010_100_101, 16'h0,    3'd4, 16'h24C5));
        tbl.push_back(mk(9'b001_111_100, 16'h0,    3'd7, 16'h24C5));
        tbl.push_back(mk(9'b111_111_011, 16'h7777, 3'd7, 16'h24C5));
        tbl.push_back(mk(9'b100_000_000, 16'd0,    3'd0, 16'd0));
        // Program R: reset while add is in its ALU cycle
        pR = tbl.size();
        tbl.push_back(mk(9'b000_000_000, 16'd9,    3'd0, 16'd9));
        tbl.push_back(mk(9'b010_001_000, 16'd0,    3'd1, 16'd18));
        tbl.push_back(mk(9'b100_000_000, 16'd0,    3'd0, 16'd0));
        // Program S: reset during STEP
        pS = tbl.size();
        tbl.push_back(mk(9'b000_010_000, 16'h0055, 3'd2, 16'h0055));
        tbl.push_back(mk(9'b100_000_000, 16'd0,    3'd0, 16'd0));

        // Reset state
        load_prog(0, nxt);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_step", {31'h0, step}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        for (int r = 0; r < 8; r++) check_reg($sformatf("rst_R%0d", r), r[2:0], 16'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        run(200);
        chk("A_steps", nsteps, 32'd5);
        chk("A_done", {31'h0, done}, 32'h1);
        check_reg("A_r0", 3'd0, 16'd9);
        check_reg("A_r1", 3'd1, 16'd18);
        check_reg("A_r2", 3'd2, 16'd27);

        // Halt hold with a changing instruction bus
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            instruction = 9'($urandom);
            data_var    = 16'($urandom);
            chk($sformatf("hold_step_c%0d", c), {31'h0, step}, 32'h0);
            chk($sformatf("hold_done_c%0d", c), {31'h0, done}, 32'h1);
        end
        check_reg("hold_r0", 3'd0, 16'd9);
        check_reg("hold_r1", 3'd1, 16'd18);
        check_reg("hold_r2", 3'd2, 16'd27);

        // Step timing
        load_prog(pT, nxt);
        do_reset();
        run(200);
        chk("T_steps", nsteps, 32'd3);
        if (step_cyc.size() >= 3) begin
            chk("T_step1_cycle", step_cyc[0], 32'd3);
            chk("T_step2_cycle", step_cyc[1], 32'd7);
            chk("T_step3_cycle", step_cyc[2], 32'd12);
        end else begin
            nvec++; nbad++;
            $display("FAIL T_step_cycles: got %0d pulses expected 3", step_cyc.size());
        end

        // Wrap-around and NOPs
        load_prog(pB, nxt);
        do_reset();
        run(400);
        chk("B_steps", nsteps, 32'd10);
        check_reg("B_r3", 3'd3, 16'h0000);
        check_reg("B_r4", 3'd4, 16'h24C5);

        // Reset in ALU of add r1,r0 (cycle 7); ROM address is not rewound
        begin
            exp_t e;
            load_prog(pR, nxt);
            do_reset();
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                if (step) begin pc++; drive_rom(); end
            end
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("R_step_after_rst", {31'h0, step}, 32'h0);
            chk("R_done_after_rst", {31'h0, done}, 32'h0);
            check_reg("R_r1_after_rst", 3'd1, 16'h0);
            check_reg("R_r0_after_rst", 3'd0, 16'h0);
            reset = 1'b0;
            sbq.delete();
            e.r = 3'd1; e.v = 16'h0;
            sbq.push_back(e);
            run(100);
            chk("R_pc_kept", pc, 32'd2);
            if (step_cyc.size() >= 1) chk("R_fetch_after_rst", step_cyc[0], 32'd4);
            else begin
                nvec++; nbad++;
                $display("FAIL R_fetch_after_rst: got no step expected step at cycle 4");
            end
        end

        // Reset during STEP drops step on that edge
        load_prog(pS, nxt);
        do_reset();
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("S_step_high", {31'h0, step}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("S_step_dropped", {31'h0, step}, 32'h0);
        check_reg("S_r2_cleared", 3'd2, 16'h0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
